// File: rtl/alu_exec.sv
// alu_exec: 16-bit execute stage feeding the write port of an 8x16 register file.
//
// A request is accepted on a rising edge where i_Start=1 and o_Busy=0. ALU and
// shift ops produce their result at the accept edge and go straight to the
// writeback state. MUL runs a 16-cycle LSB-first add-shift loop before
// writeback. Writeback lasts one cycle: o_fWE and o_Done pulse together.
//
// Build option: define ALU_MUL_EN to include the multiplier. When ALU_MUL_EN is
// not defined, opcode 111 completes (o_Done pulses) without writing anything.
//
// Ports:
//   i_Clk    clock, rising edge
//   i_Rst    asynchronous active-low reset
//   i_Start  request strobe
//   i_Op     000 ADD 001 SUB 010 AND 011 OR 100 XOR 101 SHL 110 SHR 111 MUL
//   i_Rd     destination register index
//   i_A/i_B  operands
//   o_Busy   high outside IDLE
//   o_fWE    register file write enable (one-cycle pulse)
//   o_Rd     register file write index
//   o_Data   register file write data
//   o_Done   one-cycle completion pulse
//   o_Zero   last written result was zero
//   o_Carry  last carry / borrow / shifted-out bit / multiply overflow
module alu_exec (
  input  logic        i_Clk,
  input  logic        i_Rst,
  input  logic        i_Start,
  input  logic [2:0]  i_Op,
  input  logic [2:0]  i_Rd,
  input  logic [15:0] i_A,
  input  logic [15:0] i_B,
  output logic        o_Busy,
  output logic        o_fWE,
  output logic [2:0]  o_Rd,
  output logic [15:0] o_Data,
  output logic        o_Done,
  output logic        o_Zero,
  output logic        o_Carry
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [1:0]  state;

  // Single-cycle result: bit 16 is the carry flag for every op.
  logic [16:0] wide;
  logic [16:0] shr_ext;

  always_comb begin
    wide    = '0;
    // Shift right with one guard bit below the LSB: the guard bit ends up
    // holding the last bit shifted out (0 for a zero shift amount).
    shr_ext = {i_A, 1'b0} >> i_B[3:0];
    case (i_Op)
      OP_ADD:  wide = {1'b0, i_A} + {1'b0, i_B};
      OP_SUB:  wide = {1'b0, i_A} - {1'b0, i_B};
      OP_AND:  wide = {1'b0, i_A & i_B};
      OP_OR:   wide = {1'b0, i_A | i_B};
      OP_XOR:  wide = {1'b0, i_A ^ i_B};
      OP_SHL:  wide = {1'b0, i_A} << i_B[3:0];
      OP_SHR:  wide = {shr_ext[0], shr_ext[16:1]};
      default: wide = '0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [31:0] acc;
  logic [3:0]  cnt;
  logic [2:0]  rd_q;
  logic [31:0] acc_next;

  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end
`endif

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state   <= IDLE;
      o_Busy  <= 1'b0;
      o_fWE   <= 1'b0;
      o_Done  <= 1'b0;
      o_Rd    <= '0;
      o_Data  <= '0;
      o_Zero  <= 1'b0;
      o_Carry <= 1'b0;
`ifdef ALU_MUL_EN
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      rd_q    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_Start) begin
            o_Busy <= 1'b1;
            if (i_Op == OP_MUL) begin
`ifdef ALU_MUL_EN
              mcand  <= {16'h0000, i_A};
              mplier <= i_B;
              acc    <= '0;
              cnt    <= '0;
              rd_q   <= i_Rd;
              state  <= MUL;
`else
              // Completes without touching the register file or the flags.
              o_Done <= 1'b1;
              o_fWE  <= 1'b0;
              state  <= WB;
`endif
            end else begin
              o_Data  <= wide[15:0];
              o_Carry <= wide[16];
              o_Zero  <= (wide[15:0] == '0);
              o_Rd    <= i_Rd;
              o_Done  <= 1'b1;
              o_fWE   <= 1'b1;
              state   <= WB;
            end
          end
        end
`ifdef ALU_MUL_EN
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            o_Data  <= acc_next[15:0];
            o_Carry <= |acc_next[31:16];
            o_Zero  <= (acc_next[15:0] == '0);
            o_Rd    <= rd_q;
            o_Done  <= 1'b1;
            o_fWE   <= 1'b1;
            state   <= WB;
          end
        end
`endif
        WB: begin
          o_Busy <= 1'b0;
          o_Done <= 1'b0;
          o_fWE  <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          o_Busy <= 1'b0;
          o_Done <= 1'b0;
          o_fWE  <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
